cmd_wr_shk: RTL

//  Command-packet transmitter, the opposite end of the command receive path. Snapshots a cmd array on an update pulse.

---
 rtl/cmd_shk_pkg.sv | 40 ++++
 rtl/shk_byte_ser.sv | 79 +++++++
 rtl/cmd_wr_shk.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cmd_shk_pkg.sv
// ----------------------------------------------------------------------------
// cmd_shk_pkg
//   Constants shared by the command transmitter and the command receiver:
//   frame start word, frame geometry, frame word positions, the transmitter
//   state encoding and a ceil-log2 helper used to size counters.
//   No ports (package).
// ----------------------------------------------------------------------------
package cmd_shk_pkg;

    localparam logic [31:0] MD_CMD_START = 32'h1331_0001;
    localparam int          NB_PKG_SIZE  = 244;
    localparam int          NB_PKG_HEAD  = 3;
    localparam int          NB_CMD_ORDE  = 128;

    // Fixed word positions inside a frame
    localparam int IDX_START = 0;
    localparam int IDX_LEN   = 1;
    localparam int IDX_SEQ   = 2;

    // Transmitter states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Bits needed to hold values 0..value-1; never returns less than 1
    function automatic int LOG2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shk_byte_ser.sv
// ----------------------------------------------------------------------------
// shk_byte_ser
//   Loads one command word and presents it byte by byte, LSB first, on a
//   valid/ready byte bus. A load issued in the same cycle as the last byte's
//   transfer chains the next word with no bubble.
// Ports
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   load       in   take word/base_addr and start presenting its byte 0
//   word       in   word to serialise
//   base_addr  in   byte index reported for byte 0 of the loaded word
//   ready      in   sink ready
//   valid      out  byte valid
//   mdata      out  current byte
//   maddr      out  current byte index
//   held_word  out  word currently being serialised
//   last_xfer  out  the word's last byte transfers this cycle
// ----------------------------------------------------------------------------
module shk_byte_ser
    import cmd_shk_pkg::*;
#(
    parameter int WD_CMD_DATA = 32,
    parameter int WD_SHK_DATA = 8,
    parameter int WD_SHK_ADDR = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [WD_CMD_DATA-1:0] word,
    input  logic [WD_SHK_ADDR-1:0] base_addr,
    input  logic                   ready,
    output logic                   valid,
    output logic [WD_SHK_DATA-1:0] mdata,
    output logic [WD_SHK_ADDR-1:0] maddr,
    output logic [WD_CMD_DATA-1:0] held_word,
    output logic                   last_xfer
);

    localparam int NB_BYTES = WD_CMD_DATA / WD_SHK_DATA;
    localparam int WD_BIDX  = LOG2(NB_BYTES);
    localparam logic [WD_BIDX-1:0] BIDX_LAST = WD_BIDX'(NB_BYTES - 1);

    logic [WD_CMD_DATA-1:0] word_q;
    logic [WD_BIDX-1:0]     byte_idx;
    logic [WD_SHK_ADDR-1:0] addr_q;
    logic                   valid_q;

    always_comb begin
        mdata     = WD_SHK_DATA'(word_q >> (int'(byte_idx) * WD_SHK_DATA));
        maddr     = addr_q;
        valid     = valid_q;
        held_word = word_q;
        last_xfer = valid_q && ready && (byte_idx == BIDX_LAST);
    end

    // Load wins over the transfer bookkeeping so a chained word replaces the
    // finishing one at the same edge; data and address only move on a transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            word_q   <= '0;
            byte_idx <= '0;
            addr_q   <= '0;
        end else if (load) begin
            valid_q  <= 1'b1;
            word_q   <= word;
            byte_idx <= '0;
            addr_q   <= base_addr;
        end else if (valid_q && ready) begin
            if (byte_idx == BIDX_LAST) begin
                valid_q <= 1'b0;
            end else begin
                byte_idx <= byte_idx + 1'b1;
                addr_q   <= addr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_wr_shk.sv
// ----------------------------------------------------------------------------
// cmd_wr_shk
//   Command-packet transmitter. Snapshots the command array on a request,
//   frames it as [start | length | sequence | payload | zero pad | xor] and
//   sends the frame LSB-first over a shk byte master, then holds off for a
//   fixed idle gap so the far-side receiver sees the frame boundary.
// Ports
//   i_sys_clk        in   clock
//   i_sys_reset      in   synchronous active-high reset
//   s_cmd_src_arry   in   command words, word j at [W*(j+1)-1:W*j]
//   s_cmd_src_updt   in   one-cycle send request
//   m_shk_tx_valid   out  byte valid
//   m_shk_tx_mdata   out  byte
//   m_shk_tx_maddr   out  byte index within the frame (truncated)
//   m_shk_tx_ready   in   sink ready
//   o_tx_busy        out  request accepted, frame or gap in progress
//   o_tx_done        out  pulse on the transfer of the frame's final byte
//   m_err_cmd_info1  out  sticky errors: [0] merged request, [1] sink stall
// ----------------------------------------------------------------------------
module cmd_wr_shk
    import cmd_shk_pkg::*;
#(
    parameter int WD_CMD_DATA    = 32,
    parameter int WD_SHK_DATA    = 8,
    parameter int WD_SHK_ADDR    = 16,
    parameter int NB_GAP_CYCLES  = 1024,
    parameter int WD_ERR_INFO    = 4,
    parameter int NB_STALL_LIMIT = 1 << 20
) (
    input  logic                               i_sys_clk,
    input  logic                               i_sys_reset,
    input  logic [WD_CMD_DATA*NB_CMD_ORDE-1:0] s_cmd_src_arry,
    input  logic                               s_cmd_src_updt,
    output logic                               m_shk_tx_valid,
    output logic [WD_SHK_DATA-1:0]             m_shk_tx_mdata,
    output logic [WD_SHK_ADDR-1:0]             m_shk_tx_maddr,
    input  logic                               m_shk_tx_ready,
    output logic                               o_tx_busy,
    output logic                               o_tx_done,
    output logic [WD_ERR_INFO-1:0]             m_err_cmd_info1
);

    localparam int WD_WIDX  = LOG2(NB_PKG_SIZE);
    localparam int WD_PIDX  = LOG2(NB_CMD_ORDE);
    localparam int WD_GAP   = LOG2(NB_GAP_CYCLES);
    localparam int WD_STALL = LOG2(NB_STALL_LIMIT + 1);

    localparam logic [WD_WIDX-1:0]  W_START   = WD_WIDX'(IDX_START);
    localparam logic [WD_WIDX-1:0]  W_LEN     = WD_WIDX'(IDX_LEN);
    localparam logic [WD_WIDX-1:0]  W_SEQ     = WD_WIDX'(IDX_SEQ);
    localparam logic [WD_WIDX-1:0]  W_PAY0    = WD_WIDX'(NB_PKG_HEAD);
    localparam logic [WD_WIDX-1:0]  W_PAD0    = WD_WIDX'(NB_PKG_HEAD + NB_CMD_ORDE);
    localparam logic [WD_WIDX-1:0]  W_LAST    = WD_WIDX'(NB_PKG_SIZE - 1);
    localparam logic [WD_GAP-1:0]   GAP_LAST  = WD_GAP'(NB_GAP_CYCLES - 1);
    localparam logic [WD_STALL-1:0] STALL_MAX = WD_STALL'(NB_STALL_LIMIT);

    logic [1:0]                         state;
    logic [WD_WIDX-1:0]                 word_idx;
    logic [WD_CMD_DATA*NB_CMD_ORDE-1:0] snapshot;
    logic [WD_CMD_DATA-1:0]             seq_cnt;
    logic [WD_CMD_DATA-1:0]             xor_acc;
    logic [WD_GAP-1:0]                  gap_cnt;
    logic [WD_STALL-1:0]                stall_cnt;
    logic                               pending;
    logic                               err_merge;
    logic                               err_stall;

    logic                   start;
    logic                   chain;
    logic                   frame_end;
    logic                   ser_load;
    logic [WD_SHK_ADDR-1:0] base_addr;
    logic [WD_WIDX-1:0]     load_idx;
    logic [WD_PIDX-1:0]     pay_idx;
    logic [WD_CMD_DATA-1:0] load_word;
    logic [WD_CMD_DATA-1:0] held_word;
    logic                   last_xfer;

    shk_byte_ser #(
        .WD_CMD_DATA (WD_CMD_DATA),
        .WD_SHK_DATA (WD_SHK_DATA),
        .WD_SHK_ADDR (WD_SHK_ADDR)
    ) u_ser (
        .clk       (i_sys_clk),
        .reset     (i_sys_reset),
        .load      (ser_load),
        .word      (load_word),
        .base_addr (base_addr),
        .ready     (m_shk_tx_ready),
        .valid     (m_shk_tx_valid),
        .mdata     (m_shk_tx_mdata),
        .maddr     (m_shk_tx_maddr),
        .held_word (held_word),
        .last_xfer (last_xfer)
    );

    // The next word is handed to the serialiser in the cycle the current
    // word's last byte transfers, so words follow each other without a gap.
    always_comb begin
        start     = (state == ST_IDLE) && (s_cmd_src_updt || pending);
        chain     = (state == ST_SEND) && last_xfer && (word_idx != W_LAST);
        frame_end = (state == ST_SEND) && last_xfer && (word_idx == W_LAST);
        ser_load  = start || chain;
        base_addr = start ? '0 : m_shk_tx_maddr + 1'b1;
        o_tx_done = frame_end;
        o_tx_busy = (state != ST_IDLE);
        m_err_cmd_info1 = WD_ERR_INFO'({err_stall, err_merge});
    end

    // Word map. Word 0 never depends on the snapshot, which is why the start
    // word can be loaded in the same cycle the snapshot is captured. The xor
    // word folds in the word still held by the serialiser, because the
    // accumulator only absorbs it at this same edge.
    always_comb begin
        load_idx  = start ? W_START : word_idx + 1'b1;
        pay_idx   = WD_PIDX'(load_idx - W_PAY0);
        load_word = '0;
        if (load_idx == W_START) begin
            load_word = WD_CMD_DATA'(MD_CMD_START);
        end else if (load_idx == W_LEN) begin
            load_word = WD_CMD_DATA'(NB_CMD_ORDE);
        end else if (load_idx == W_SEQ) begin
            load_word = seq_cnt;
        end else if (load_idx == W_LAST) begin
            load_word = xor_acc ^ held_word;
        end else if ((load_idx >= W_PAY0) && (load_idx < W_PAD0)) begin
            load_word = snapshot[int'(pay_idx)*WD_CMD_DATA +: WD_CMD_DATA];
        end
    end

    // Frame sequencing: word counter, xor accumulator, sequence count,
    // post-frame gap and sink-stall watchdog.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            state     <= ST_IDLE;
            word_idx  <= '0;
            snapshot  <= '0;
            seq_cnt   <= '0;
            xor_acc   <= '0;
            gap_cnt   <= '0;
            stall_cnt <= '0;
            err_stall <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SEND;
                        snapshot  <= s_cmd_src_arry;
                        word_idx  <= '0;
                        xor_acc   <= '0;
                        stall_cnt <= '0;
                    end
                end
                ST_SEND: begin
                    if (last_xfer) begin
                        xor_acc <= xor_acc ^ held_word;
                        if (word_idx == W_LAST) begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                            seq_cnt <= seq_cnt + 1'b1;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                    // Counts consecutive stalled cycles; flags once the run
                    // exceeds the limit and then stops counting.
                    if (!m_shk_tx_ready) begin
                        if (stall_cnt == STALL_MAX) begin
                            err_stall <= 1'b1;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Requests arriving while busy are remembered once; a second one before
    // the first is served is merged and flagged. A request coinciding with
    // the start of a frame is absorbed by that frame.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            pending   <= 1'b0;
            err_merge <= 1'b0;
        end else if (start) begin
            pending <= 1'b0;
        end else if (s_cmd_src_updt && (state != ST_IDLE)) begin
            if (pending) begin
                err_merge <= 1'b1;
            end else begin
                pending <= 1'b1;
            end
        end
    end

endmodule
